// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and types for the register file and ALU
package cpu_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - register file read/write-back bus; master drives indices and write-back
interface reg_file_if;
  import cpu_pkg::*;

  reg_addr_t rs_addr;
  reg_addr_t rt_addr;
  logic      wr_en;
  reg_addr_t rd_addr;
  data_t     wr_data;
  data_t     rs_data;
  data_t     rt_data;

  modport master (
    output rs_addr, rt_addr, wr_en, rd_addr, wr_data,
    input  rs_data, rt_data
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, rd_addr, wr_data,
    output rs_data, rt_data
  );
endinterface

// File: rtl/reg_file_read_port.sv
// rtl/reg_file_read_port.sv - one combinational read port: index mux, r0 forcing, write-through
// under REGFILE_BYPASS_EN
module reg_read_port
  import cpu_pkg::*;
(
  input  data_t     mem [NUM_REGS],
  input  reg_addr_t addr,
  input  logic      wr_en,
  input  reg_addr_t rd_addr,
  input  data_t     wr_data,
  input  logic      rst,
  output data_t     data
);

  always_comb begin
    data = mem[addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !rst && (rd_addr == addr)) begin
      data = wr_data;
    end
`endif
    // r0 forcing comes last so it also overrides any bypass
    if (addr == REG_ZERO) begin
      data = '0;
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass_inputs;
  assign unused_bypass_inputs = ^{wr_en, rd_addr, wr_data, rst};
`endif

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32 x 32 integer register file feeding ALU inp1/inp2; r0 hardwired to zero,
// optional write-through selected by REGFILE_BYPASS_EN
module reg_file
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);

  data_t mem [NUM_REGS];
  data_t rs_q;
  data_t rt_q;

  // flops rather than RAM so every entry can clear in one reset cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.wr_en && (bus.rd_addr != REG_ZERO)) begin
      mem[bus.rd_addr] <= bus.wr_data;
    end
  end

  reg_read_port u_rs_port (
    .mem     (mem),
    .addr    (bus.rs_addr),
    .wr_en   (bus.wr_en),
    .rd_addr (bus.rd_addr),
    .wr_data (bus.wr_data),
    .rst     (rst),
    .data    (rs_q)
  );

  reg_read_port u_rt_port (
    .mem     (mem),
    .addr    (bus.rt_addr),
    .wr_en   (bus.wr_en),
    .rd_addr (bus.rd_addr),
    .wr_data (bus.wr_data),
    .rst     (rst),
    .data    (rt_q)
  );

  assign bus.rs_data = rs_q;
  assign bus.rt_data = rt_q;

endmodule
